// File: rtl/mini_core_dmem_bridge_pkg.sv
// Shared core/memory types plus the data-memory bridge state
// encoding and timeout fill value.
package mini_core_pkg;

  typedef struct packed {
    logic        WrEn;
    logic        RdEn;
    logic [31:0] Address;
    logic [31:0] WrData;
    logic [3:0]  ByteEn;
  } t_core2mem_req;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    DONE
  } t_dmem_bridge_st;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mini_core_dmem_bridge_if.sv
// Valid/ready data-memory bus between the bridge (master)
// and the memory system (slave).
interface mini_core_dmem_bridge_if;
  logic        MemReqValid;
  logic        MemReqReady;
  logic        MemReqWrEn;
  logic [31:0] MemReqAddr;
  logic [31:0] MemReqWrData;
  logic [3:0]  MemReqByteEn;
  logic        MemRspValid;
  logic [31:0] MemRspData;

  modport master (
    output MemReqValid,
    output MemReqWrEn,
    output MemReqAddr,
    output MemReqWrData,
    output MemReqByteEn,
    input  MemReqReady,
    input  MemRspValid,
    input  MemRspData
  );

  modport slave (
    input  MemReqValid,
    input  MemReqWrEn,
    input  MemReqAddr,
    input  MemReqWrData,
    input  MemReqByteEn,
    output MemReqReady,
    output MemRspValid,
    output MemRspData
  );
endinterface

// File: rtl/mini_core_dmem_bridge.sv
// Turns the core's Q103H data request into one bus transaction,
// stalling the core until it completes or times out.
module mini_core_dmem_bridge
  import mini_core_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = DMEM_ERR_DATA
) (
  input  logic          Clock,
  input  logic          Rst,
  input  t_core2mem_req Core2DmemReqQ103H,
  output logic          DMemReady,
  output logic [31:0]   DMemRdRspQ104H,
  output logic          DMemErr,
  mini_core_dmem_bridge_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  t_dmem_bridge_st state_q, state_d;

  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rsp_q, rsp_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic req_valid;
  logic to_hit;

  assign req_valid = Core2DmemReqQ103H.RdEn
                   | Core2DmemReqQ103H.WrEn;
  assign to_hit = (cnt_q == TO_LAST);

  always_ff @(posedge Clock) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (req_valid) state_d = SEND;
      SEND:
        if (bus.MemReqReady)
          state_d = wr_q ? DONE : WAIT_RSP;
      WAIT_RSP:
        if (bus.MemRspValid || to_hit)
          state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    DMemReady = ((state_q == IDLE) && !req_valid)
              || (state_q == DONE);
    bus.MemReqValid = (state_q == SEND);
  end

  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:
        if (req_valid) begin
          wr_d    = Core2DmemReqQ103H.WrEn;
          addr_d  = Core2DmemReqQ103H.Address;
          wdata_d = Core2DmemReqQ103H.WrData;
          be_d    = Core2DmemReqQ103H.ByteEn;
          if (Core2DmemReqQ103H.RdEn
              && Core2DmemReqQ103H.WrEn)
            err_d = 1'b1;
        end
      SEND:
        cnt_d = '0;
      WAIT_RSP: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // a response on the timeout cycle still wins
        if (bus.MemRspValid) begin
          rsp_d = bus.MemRspData;
        end else if (to_hit) begin
          rsp_d = ERR_DATA;
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.MemReqWrEn   = wr_q;
  assign bus.MemReqAddr   = addr_q;
  assign bus.MemReqWrData = wdata_q;
  assign bus.MemReqByteEn = be_q;
  assign DMemRdRspQ104H   = rsp_q;
  assign DMemErr          = err_q;

endmodule

// File: doc/mini_core_dmem_bridge.md
Name: mini_core_dmem_bridge

Overview:
Sits directly downstream of the core's Q103H memory-access stage, between the core's data-memory request and a variable-latency valid/ready data-memory bus. It converts the core's single request into a bus transaction and stalls the core through DMemReady while the transaction is outstanding. It returns load data on DMemRdRspQ104H for the core's Q104H write-back, and enforces a response timeout with a sticky error flag.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT_RSP before a read is force-completed (>=2)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
Clock  in  1  core clock
Rst  in  1  synchronous, active-high reset
Core2DmemReqQ103H  in  t_core2mem_req  fields WrEn, RdEn, Address[31:0], WrData[31:0], ByteEn[3:0]
DMemReady  out  1  to core; high = Q103H request complete / no request pending
DMemRdRspQ104H  out  32  registered load data to core
MemReqValid  out  1  bus request valid
MemReqReady  in  1  bus accepts request
MemReqWrEn  out  1  1=write, 0=read
MemReqAddr  out  32  bus address
MemReqWrData  out  32  bus write data
MemReqByteEn  out  4  bus byte enables
MemRspValid  in  1  read response valid
MemRspData  in  32  read response data
DMemErr  out  1  sticky: timeout or illegal request seen

Behaviour:
- One clock (Clock). Reset is synchronous, active-high (Rst), and applies in any state.
- Reset values: state IDLE; MemReqValid=0; MemReqWrEn=0; MemReqAddr=0; MemReqWrData=0; MemReqByteEn=0; DMemRdRspQ104H=0; DMemErr=0; timeout counter=0.
- Reset mid-transaction drops the transaction, with no bus retry. A MemRspValid arriving outside WAIT_RSP is ignored.
- FSM states: IDLE, SEND, WAIT_RSP, DONE.
- IDLE:
  - ReqValid = RdEn|WrEn.
  - On ReqValid: capture Address, WrData, ByteEn and the kind into holding registers, then go to SEND.
  - Kind = write if WrEn=1. If RdEn&WrEn both set, treat as a write and set DMemErr.
- SEND:
  - MemReqValid=1; bus fields are driven from the holding registers and stay stable until accepted.
  - On MemReqReady: a write goes to DONE, a read goes to WAIT_RSP with counter cleared.
  - No timeout applies while in SEND.
- WAIT_RSP:
  - Counter increments each cycle.
  - On MemRspValid: DMemRdRspQ104H<=MemRspData, go to DONE.
  - Else if counter==TIMEOUT_CYCLES-1: DMemRdRspQ104H<=ERR_DATA, DMemErr<=1, go to DONE.
  - If MemRspValid arrives on the timeout cycle, the response wins and no error is raised.
- DONE:
  - The core's advance point. The Q103H input is ignored this cycle because it is the same stalled request.
  - Next state is unconditionally IDLE.
- DMemReady (combinational) = (IDLE && !ReqValid) || DONE. It is low in the IDLE cycle that sees a new request, and low in SEND and WAIT_RSP.
- DMemRdRspQ104H holds its value until the next read completes; writes do not change it.
- Minimum latency, from the request-present cycle C (IDLE):
  - Write: DMemReady=1 at C+2 (SEND accepted at C+1).
  - Read: rsp at C+2 gives DMemReady=1 at C+3, with data valid on DMemRdRspQ104H from C+4.
  - Back-to-back requests incur one IDLE cycle between them.
- DMemErr clears only on Rst.
- Timeout counter width is $clog2(TIMEOUT_CYCLES)+1. The counter saturates and never wraps.

Decomposition:
- Add to mini_core_pkg:
  - the t_core2mem_req field definition shown above, shared with the core;
  - t_dmem_bridge_st enum (IDLE, SEND, WAIT_RSP, DONE);
  - the DMEM_ERR_DATA default constant.
- A single module with no sub-module. The timeout counter is a few lines inline.

Test Plan:
- Write, MemReqReady=1 immediately: WrEn, Addr=0x100, WrData=0x12345678, ByteEn=4'hF -> bus shows those values at C+1; DMemReady=0 at C,C+1 and 1 at C+2; DMemRdRspQ104H unchanged.
- Read with ready stalled 3 cycles and rsp 2 cycles later, MemRspData=0xCAFEF00D -> MemReqValid stays high with stable fields until accepted; DMemRdRspQ104H=0xCAFEF00D the cycle after DMemReady=1; DMemErr=0.
- Timeout, TIMEOUT_CYCLES=4, no MemRspValid -> DONE after 4 WAIT_RSP cycles; DMemRdRspQ104H=0xDEADBEEF; DMemErr=1 and stays 1 through later good reads.
- Rsp on the exact timeout cycle -> data=MemRspData, DMemErr=0.
- Rst asserted during WAIT_RSP, then a late MemRspValid=1 -> all outputs at reset values; stray rsp ignored; next read completes normally.
- RdEn=WrEn=1 -> bus write issued (MemReqWrEn=1), DMemErr=1. A back-to-back read follows one IDLE cycle after DONE.
